// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD block family.
//   BCD_DIGIT_W / BCD_MAX_DIGIT : nibble width and the largest legal digit value
//   bcd_state_e                 : converter FSM state encoding
//   bcd_min_bin_w()             : smallest binary width that holds any DIGITS-digit value
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_e;

  // Smallest w with 2^w > 10^digits - 1, i.e. 2^w >= 10^digits.
  function automatic int unsigned bcd_min_bin_w(input int unsigned digits);
    longint unsigned lim;
    int unsigned     w;
    lim = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      lim = lim * 64'd10;
    end
    w = 0;
    while ((64'd1 << w) < lim) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_bin_conv_if.sv
// Handshake bundle for bcd_to_bin_conv.
//   in_valid/in_ready/bcd_in           : word input (producer -> converter)
//   out_valid/out_ready/out_data/out_err : result output (converter -> consumer)
// Modports: master = the side driving words in and taking results; slave = the converter.
interface bcd_to_bin_conv_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_data;
  logic                  out_err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: acc_out = acc_in*10 + digit (mod 2^BIN_W).
//   acc_in    : running accumulator
//   digit     : next BCD nibble
//   acc_out   : updated accumulator
//   digit_gt9 : nibble is not a legal BCD digit (constant 0 unless BCD_DIGIT_CHECK_EN)
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc_in,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       acc_out,
  output logic                   digit_gt9
);

  // x*10 as x*8 + x*2, kept in BIN_W bits.
  assign acc_out = (acc_in << 3) + (acc_in << 1) + BIN_W'(digit);

`ifdef BCD_DIGIT_CHECK_EN
  assign digit_gt9 = (digit > BCD_MAX_DIGIT);
`else
  assign digit_gt9 = 1'b0;
`endif

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Iterative BCD-to-binary converter, one digit per clock, most significant digit first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_to_bin_conv_if.slave (in_valid/in_ready/bcd_in, out_valid/out_ready/
//           out_data/out_err)
// Optional macro BCD_DIGIT_CHECK_EN: flag nibbles > 9; a flagged word reports out_err=1 and
// out_data=0. Without it, nibbles are weighted raw and out_err is tied to 0.
module bcd_to_bin_conv
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_conv_if.slave bus
);

  localparam int unsigned WORD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "bcd_to_bin_conv: DIGITS must be 1..8");
  end
  if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bad_width
    $fatal(1, "bcd_to_bin_conv: BIN_W too small for DIGITS");
  end

  bcd_state_e       state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [BIN_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [BIN_W-1:0] out_data_q;

  logic [BIN_W-1:0] acc_next;
  logic             digit_gt9;
  logic             err_next;
  logic             last_digit;

  bcd_mac10 #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc_in    (acc_q),
    .digit     (shreg_q[WORD_W-1 -: BCD_DIGIT_W]),
    .acc_out   (acc_next),
    .digit_gt9 (digit_gt9)
  );

  assign last_digit = (state_q == ST_CONV) && (cnt_q == CNT_LAST);

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q;
  logic out_err_q;

  // Sticky per-word flag, including the digit being consumed this cycle.
  assign err_next = err_q | digit_gt9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.in_valid && in_ready_q) begin
      err_q <= 1'b0;
    end else if (state_q == ST_CONV) begin
      err_q <= err_next;
      if (last_digit) begin
        out_err_q <= err_next;
      end
    end
  end

  assign bus.out_err = out_err_q;
`else
  logic unused_gt9;
  assign unused_gt9  = digit_gt9;
  assign err_next    = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            shreg_q    <= bus.bcd_in;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc_q   <= acc_next;
          shreg_q <= shreg_q << BCD_DIGIT_W;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_digit) begin
            out_data_q  <= err_next ? '0 : acc_next;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Self-checking bench for bcd_to_bin_conv (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_conv;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    logic [13:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_to_bin_conv_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_conv #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: a result handshake happens on the next rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result: got data %0d with no word outstanding", bus.out_data);
      end else begin
        e = sb.pop_front();
        check("result_data", 32'(bus.out_data), 32'(e.data));
        check("result_err", 32'(bus.out_err), 32'(e.err));
        pops++;
      end
    end
  end

  // Present a word until accepted; push its expected result at acceptance.
  task automatic send(input logic [15:0] w, input logic [13:0] d, input logic e,
                      input bit keep);
    bit   hs;
    int   n;
    exp_t x;
    hs = 1'b0;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.bcd_in   = w;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!keep) bus.in_valid = 1'b0;
    if (hs) begin
      x.data = d;
      x.err  = e;
      sb.push_back(x);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, expected acceptance", w);
    end
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    int k;
    int pops0;

    vecs[0] = '{bcd: 16'h9999, data: 14'd9999, err: 1'b0};
    vecs[1] = '{bcd: 16'h0042, data: 14'd42,   err: 1'b0};
`ifdef BCD_DIGIT_CHECK_EN
    vecs[2] = '{bcd: 16'h12A4, data: 14'd0,    err: 1'b1};
`else
    vecs[2] = '{bcd: 16'h12A4, data: 14'd1304, err: 1'b0};
`endif
    vecs[3] = '{bcd: 16'h0001, data: 14'd1,    err: 1'b0};
    vecs[4] = '{bcd: 16'h8000, data: 14'd8000, err: 1'b0};
    vecs[5] = '{bcd: 16'h0909, data: 14'd909,  err: 1'b0};
    vecs[6] = '{bcd: 16'h1000, data: 14'd1000, err: 1'b0};

    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_out_err", 32'(bus.out_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: result valid exactly DIGITS edges after acceptance.
    send(16'h0000, 14'd0, 1'b0, 1'b0);
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_valid(k);
    check("latency", 32'(k), 32'(DIGITS));
    bus.out_ready = 1'b1;
    wait_drain();
    bus.out_ready = 1'b0;

    // Back-pressure: result held stable while out_ready is low.
    send(16'h1234, 14'd1234, 1'b0, 1'b0);
    wait_valid(k);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'd1234);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("hold_popped", 32'(sb.size()), 32'd0);

    // Table vectors, out_ready high.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].bcd, vecs[i].data, vecs[i].err, 1'b0);
      wait_drain();
    end

    // Reset two cycles into a conversion discards the word.
    send(16'h5678, 14'd5678, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_data", 32'(bus.out_data), 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0042, 14'd42, 1'b0, 1'b0);
    wait_drain();

    // Decade-counter stream with in_valid held through busy cycles.
    pops0 = pops;
    for (int i = 0; i < 10; i++) begin
      send(16'(i), 14'(i), 1'b0, 1'b1);
    end
    bus.in_valid = 1'b0;
    wait_drain();
    repeat (DIGITS + 2) @(posedge clk);
    #1;
    check("stream_count", 32'(pops - pops0), 32'd10);
    check("stream_empty", 32'(sb.size()), 32'd0);
    check("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_to_bin_conv.md
Name: bcd_to_bin_conv

Overview:
Multi-digit BCD-to-binary decoder. It consumes packed BCD words produced by the team's decade counters and returns the equivalent unsigned binary value.
- Iterative, one digit per clock, most significant digit first: acc = acc*10 + digit.
- Valid/ready handshakes on both input and output.
- Sits between the BCD counter chain and binary consumers such as comparators and register files.

Parameters:
DIGITS, 4, number of BCD digits in the input word; legal range 1..8.
BIN_W, 14, output width; must satisfy 2^BIN_W > 10^DIGITS - 1 (elaboration-time check, fatal if violated).

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  bcd_in is valid
in_ready  output  1  block can accept a word
bcd_in  input  4*DIGITS  packed BCD; digit DIGITS-1 in the MS nibble
out_valid  output  1  out_data/out_err are valid
out_ready  input  1  downstream accepts the result
out_data  output  BIN_W  binary result
out_err  output  1  the word contained a nibble greater than 9 (only when the optional feature is compiled in)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_err=0; accumulator, digit counter and shift register cleared.
- State machine states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready, latch bcd_in into the shift register, clear acc to 0, clear the counter to 0, clear the error flag, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: acc <= acc*10 + shreg[MS nibble]; shreg <= shreg << 4; cnt <= cnt+1.
  - acc*10 is computed as (acc<<3)+(acc<<1), truncated to BIN_W. Overflow is impossible given the BIN_W rule.
  - After the update with cnt==DIGITS-1, go to DONE and load out_data with the final acc.
- DONE:
  - out_valid=1; out_data and out_err held stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap.
- Latency: handshake accepted at edge N -> out_valid high after edge N+DIGITS.
- Throughput: at most one word per DIGITS+2 cycles when out_ready is held high.
- in_valid while in_ready=0: ignored; bcd_in is not sampled.
- out_ready while out_valid=0: no effect.
- DIGITS=1: CONV lasts exactly one cycle.
- Reset mid-CONV or mid-DONE: the in-flight word is discarded and all outputs return to their reset values immediately.
- out_data keeps its last value after the DONE->IDLE handoff until the next result loads; consumers must qualify it with out_valid.

Optional Feature:
Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - Each digit consumed in CONV is compared against 9; any nibble >9 sets a sticky error flag for that word.
  - At DONE, out_err=flag. If the flag is set, out_data is forced to 0.
- Undefined:
  - Nibbles are used as raw 4-bit values with weight 10 (e.g. 0xA0 -> 100). No error is reported.
  - out_err is tied to 0 and the comparator logic is absent.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9.
  - State encoding constants ST_IDLE, ST_CONV, ST_DONE.
  - Function for the minimum BIN_W given DIGITS; also used by future BCD blocks.
- One natural sub-module: bcd_mac10. It is purely combinational: acc_out = acc_in*10 + digit, parameterised on BIN_W, plus a digit_gt9 flag output.
- The FSM, counter, shift register and handshakes stay in bcd_to_bin_conv.

Test Plan:
- Reset release, bcd_in=16'h0000 with in_valid pulse -> out_valid rises exactly 4 cycles after acceptance, out_data=0, out_err=0.
- bcd_in=16'h1234 -> out_data=14'd1234 (0x04D2); bcd_in=16'h9999 -> out_data=9999 (0x270F).
- Result pending with out_ready low for 5 cycles, then high -> out_data held stable throughout; out_valid drops the cycle after the handshake; in_ready=0 until back in IDLE.
- rst_n pulsed low 2 cycles into a CONV of 16'h5678 -> out_valid=0 and in_ready=1 immediately. The next word, 16'h0042, yields 42 with no contamination from the aborted word.
- With BCD_DIGIT_CHECK_EN, bcd_in=16'h12A4 -> out_err=1, out_data=0. Without the macro, the same input gives out_data=1304 and out_err=0.
- Back-to-back stream 0000..0009 as produced by the decade counter, out_ready tied high -> results 0..9 in order; in_valid held during busy cycles drops no words and duplicates none.
